cache_2way_ctrl: RTL

- Controller FSM that sits between the CPU load/store port and the 2-way cache datapath; it is the initiator that drives the datapath's enable/cmp/write/tag/index/word_sel/data/byte-enable inputs.
- Accepts one CPU word access at a time and runs the lookup.
- On a miss, writes back a dirty victim line as one 256-bit burst, refills the line word-serially from memory, then replays the access.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_refill_cnt.sv | 28 ++
 rtl/cache_2way_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared state encoding and address-field geometry for the 2-way cache
// controller and its refill beat counter.
package cache_pkg;

    localparam int CACHE_OFFSET_WIDTH = 3;
    localparam int CACHE_INDEX_WIDTH  = 6;
    localparam int CACHE_TAG_WIDTH    =
        30 - CACHE_OFFSET_WIDTH - CACHE_INDEX_WIDTH;

    // Byte address bits below the word select.
    localparam int WORD_LSB = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RESP,
        VICTIM,
        WB,
        REFILL
    } state_t;

    function automatic int index_lsb(input int offset_width);
        return offset_width + WORD_LSB;
    endfunction

    function automatic int tag_lsb(input int offset_width,
                                   input int index_width);
        return offset_width + index_width + WORD_LSB;
    endfunction

endpackage

// File: rtl/cache_refill_cnt.sv
// Refill beat counter; one extra bit so the final-beat compare never wraps.
module cache_refill_cnt #(
    parameter int OFFSET_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [OFFSET_WIDTH:0] count,
    output logic                  last
);

    localparam logic [OFFSET_WIDTH:0] LAST_BEAT =
        {1'b0, {OFFSET_WIDTH{1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LAST_BEAT);

endmodule

// File: rtl/cache_2way_ctrl.sv
// CPU-side controller for the 2-way cache datapath: lookup, dirty write-back,
// word-serial refill and replay. Define CACHE_CTRL_STATS_EN for hit/miss stats.
module cache_2way_ctrl
    import cache_pkg::*;
#(
    parameter int OFFSET_WIDTH = CACHE_OFFSET_WIDTH,
    parameter int BLOCK_SIZE   = 1 << OFFSET_WIDTH,
    parameter int INDEX_WIDTH  = CACHE_INDEX_WIDTH,
    parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    input  logic [3:0]              cpu_be,
    output logic                    cpu_ready,
    output logic [31:0]             cpu_rdata,
    output logic                    c_enable,
    output logic                    c_cmp,
    output logic                    c_write,
    output logic                    c_valid_in,
    output logic [INDEX_WIDTH-1:0]  c_index,
    output logic [OFFSET_WIDTH-1:0] c_word_sel,
    output logic [TAG_WIDTH-1:0]    c_tag_in,
    output logic [31:0]             c_data_in,
    output logic [3:0]              c_byte_w_en,
    input  logic                    c_hit,
    input  logic                    c_dirty,
    input  logic                    c_valid_out,
    input  logic [TAG_WIDTH-1:0]    c_tag_out,
    input  logic [31:0]             c_data_out,
    input  logic [32*BLOCK_SIZE-1:0] c_data_wb,
    output logic                    mem_wr_req,
    output logic [31:0]             mem_wr_addr,
    output logic [32*BLOCK_SIZE-1:0] mem_wr_data,
    input  logic                    mem_wr_ack,
    output logic                    mem_rd_req,
    output logic [31:0]             mem_rd_addr,
    input  logic                    mem_rd_valid,
    input  logic [31:0]             mem_rd_data
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]             stat_hits,
    output logic [31:0]             stat_misses
`endif
);

    localparam int IDX_LSB = index_lsb(OFFSET_WIDTH);
    localparam int TAG_LSB = tag_lsb(OFFSET_WIDTH, INDEX_WIDTH);

    state_t state, state_n;

    logic [31:0]              addr_q;
    logic [31:0]              wdata_q;
    logic [3:0]               be_q;
    logic                     we_q;
    logic                     replay_q;
    logic [31:0]              rdata_q;
    logic [31:0]              wb_addr_q;
    logic [32*BLOCK_SIZE-1:0] wb_data_q;

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_word;

    logic [OFFSET_WIDTH:0] beat_cnt;
    logic                  beat_last;
    logic                  cnt_inc;
    logic                  cnt_clear;
    logic                  unused;

    assign req_tag   = addr_q[31:TAG_LSB];
    assign req_index = addr_q[TAG_LSB-1:IDX_LSB];
    assign req_word  = addr_q[IDX_LSB-1:WORD_LSB];
    assign unused    = &{1'b0, addr_q[1:0]};

    assign cpu_rdata   = rdata_q;
    assign mem_wr_addr = wb_addr_q;
    assign mem_wr_data = wb_data_q;

    cache_refill_cnt #(
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_refill_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .count(beat_cnt),
        .last (beat_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        cpu_ready   = 1'b0;
        c_enable    = 1'b0;
        c_cmp       = 1'b0;
        c_write     = 1'b0;
        c_valid_in  = 1'b0;
        c_index     = '0;
        c_word_sel  = '0;
        c_tag_in    = '0;
        c_data_in   = '0;
        c_byte_w_en = '0;
        mem_wr_req  = 1'b0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        cnt_inc     = 1'b0;
        cnt_clear   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req) state_n = LOOKUP;
            end
            LOOKUP: begin
                c_enable    = 1'b1;
                c_cmp       = 1'b1;
                c_write     = we_q;
                c_valid_in  = 1'b1;
                c_byte_w_en = be_q;
                c_index     = req_index;
                c_word_sel  = req_word;
                c_tag_in    = req_tag;
                c_data_in   = wdata_q;
                state_n     = c_hit ? RESP : VICTIM;
            end
            RESP: begin
                cpu_ready = 1'b1;
                state_n   = IDLE;
            end
            VICTIM: begin
                c_enable = 1'b1;
                c_index  = req_index;
                c_tag_in = req_tag;
                state_n  = (c_valid_out && c_dirty) ? WB : REFILL;
            end
            WB: begin
                mem_wr_req = 1'b1;
                if (mem_wr_ack) state_n = REFILL;
            end
            REFILL: begin
                // Request stays up only until the first beat lands.
                mem_rd_req  = (beat_cnt == '0);
                mem_rd_addr = {addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
                if (mem_rd_valid) begin
                    c_enable    = 1'b1;
                    c_write     = 1'b1;
                    c_valid_in  = 1'b1;
                    c_byte_w_en = 4'hF;
                    c_index     = req_index;
                    c_word_sel  = beat_cnt[OFFSET_WIDTH-1:0];
                    c_tag_in    = req_tag;
                    c_data_in   = mem_rd_data;
                    cnt_inc     = 1'b1;
                    if (beat_last) begin
                        cnt_clear = 1'b1;
                        state_n   = LOOKUP;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            replay_q  <= 1'b0;
            rdata_q   <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                be_q    <= cpu_be;
                we_q    <= cpu_we;
            end
            if (state == LOOKUP) begin
                replay_q <= 1'b0;
                if (c_hit) rdata_q <= c_data_out;
            end
            if (state == VICTIM && c_valid_out && c_dirty) begin
                wb_addr_q <= {c_tag_out, req_index, {IDX_LSB{1'b0}}};
                wb_data_q <= c_data_wb;
            end
            if (state == REFILL && mem_rd_valid && beat_last) begin
                replay_q <= 1'b1;
            end
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == LOOKUP && !replay_q) begin
            if (c_hit) begin
                if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
            end else begin
                if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
            end
        end
    end
`endif

endmodule
